// File: rtl/reg_file_16x32_pkg.sv
// Shared constants for reg_file_16x32; defaults come from reg_file_defs.vh.
package reg_file_16x32_pkg;
`include "reg_file_defs.vh"

    localparam int RF_WIDTH     = `RF_WIDTH_DEF;
    localparam int RF_DEPTH     = `RF_DEPTH_DEF;
    localparam int RF_ADDR_W    = `RF_ADDR_W_DEF;
    localparam int RF_ZERO_ADDR = `RF_ZERO_ADDR_DEF;

endpackage

// File: rtl/reg_32bit_en.sv
// One storage word: loads d on the rising clk edge when en=1, async active-low clear.
module reg_32bit_en
    import reg_file_16x32_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_q <= '0;
        else if (en)
            r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/reg_file_defs.vh
// Default geometry of the 16x32 register file, shared by the package and the RTL.
`ifndef REG_FILE_DEFS_VH
`define REG_FILE_DEFS_VH

`define RF_WIDTH_DEF     32
`define RF_DEPTH_DEF     16
`define RF_ADDR_W_DEF    4
`define RF_ZERO_ADDR_DEF 0

`endif

// File: rtl/reg_file_16x32.sv
// Two-read, one-write register file with a hardwired-zero register 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_16x32
    import reg_file_16x32_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

    logic [DEPTH-1:0][WIDTH-1:0] w_q;
    logic [DEPTH-1:1]            w_wsel;
    logic [WIDTH-1:0]            w_rd1;
    logic [WIDTH-1:0]            w_rd2;

    // One-hot write decode; slot 0 has no select, so writes to it vanish.
    always_comb begin
        w_wsel = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (we && (waddr == ADDR_W'(i)))
                w_wsel[i] = 1'b1;
        end
    end

    assign w_q[0] = '0;

    genvar g;
    generate
        for (g = 1; g < DEPTH; g++) begin : g_word
            reg_32bit_en #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .en    (w_wsel[g]),
                .d     (wdata),
                .q     (w_q[g])
            );
        end
    endgenerate

    always_comb begin
        w_rd1 = w_q[raddr1];
        w_rd2 = w_q[raddr2];
    end

`ifdef REGFILE_BYPASS_EN
    // Forward only a write that will actually commit on the coming edge.
    logic w_wr_live;
    assign w_wr_live = we && reset && (waddr != ZERO_ADDR);

    assign rdata1 = (w_wr_live && (raddr1 == waddr)) ? wdata : w_rd1;
    assign rdata2 = (w_wr_live && (raddr2 == waddr)) ? wdata : w_rd2;
`else
    assign rdata1 = w_rd1;
    assign rdata2 = w_rd2;
`endif

endmodule

// File: tb/tb_reg_file_16x32.sv
// Directed bench for reg_file_16x32; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_16x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr1;
    logic [31:0] rdata1;
    logic [3:0]  raddr2;
    logic [31:0] rdata2;

    int n_vec = 0;
    int n_err = 0;

    reg_file_16x32 dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] byp_exp;
        logic [31:0] v;
        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = 4'd3; raddr2 = 4'd9;
        #1;
        chk("rst_rd1", rdata1, 32'h0);
        chk("rst_rd2", rdata2, 32'h0);

        @(negedge clk);
        reset = 1'b1;

        // basic write / read
        wr(4'd5, 32'hDEADBEEF);
        raddr1 = 4'd5; raddr2 = 4'd4;
        #1;
        chk("wr5_rd1", rdata1, 32'hDEADBEEF);
        chk("wr4_rd2", rdata2, 32'h0);

        // register 0 discards writes
        wr(4'd0, 32'hFFFFFFFF);
        raddr1 = 4'd0; raddr2 = 4'd0;
        #1;
        chk("zero_rd1", rdata1, 32'h0);
        chk("zero_rd2", rdata2, 32'h0);

        // bypass window before the commit edge
        @(negedge clk);
        we = 1'b1; waddr = 4'd3; wdata = 32'h12345678;
        raddr1 = 4'd3; raddr2 = 4'd5;
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'h12345678;
`else
        byp_exp = 32'h0;
`endif
        #1;
        chk("byp_rd1", rdata1, byp_exp);
        chk("byp_other_rd2", rdata2, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("byp_commit", rdata1, 32'h12345678);

        // write to address 0 never bypasses
        @(negedge clk);
        we = 1'b1; waddr = 4'd0; wdata = 32'hCAFEF00D; raddr1 = 4'd0;
        #1;
        chk("byp_zero", rdata1, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;

        // we=0 leaves storage alone
        @(negedge clk);
        waddr = 4'd5; wdata = 32'h0BADF00D; raddr1 = 4'd5;
        @(posedge clk);
        #1;
        chk("we0_hold", rdata1, 32'hDEADBEEF);

        // back-to-back writes to one address
        @(negedge clk);
        we = 1'b1; waddr = 4'd9; wdata = 32'h00000111;
        @(posedge clk);
        #1;
        wdata = 32'h00000222;
        @(posedge clk);
        #1;
        we = 1'b0; raddr1 = 4'd9; raddr2 = 4'd9;
        #1;
        chk("b2b_rd1", rdata1, 32'h00000222);
        chk("b2b_rd2", rdata2, 32'h00000222);

        // async reset mid-cycle, no clock edge in between
        @(negedge clk);
        raddr1 = 4'd5; raddr2 = 4'd3;
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_rd1", rdata1, 32'h0);
        chk("async_rst_rd2", rdata2, 32'h0);

        // reset held across an edge with a write pending
        we = 1'b1; waddr = 4'd7; wdata = 32'hA5A5A5A5; raddr1 = 4'd7;
        #1;
        chk("rst_no_byp", rdata1, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        we = 1'b0; reset = 1'b1;
        #1;
        chk("rst_vs_wr", rdata1, 32'h0);

        // first write after reset release commits
        wr(4'd7, 32'h00000077);
        #1;
        chk("post_rst_wr", rdata1, 32'h00000077);

        // full sweep
        for (int a = 1; a < 16; a++)
            wr(a[3:0], a * 32'h01010101);
        for (int a = 1; a < 16; a++) begin
            raddr1 = a[3:0];
            raddr2 = 4'((a % 15) + 1);
            #1;
            v = a * 32'h01010101;
            chk($sformatf("sweep_rd1_%0d", a), rdata1, v);
            v = ((a % 15) + 1) * 32'h01010101;
            chk($sformatf("sweep_rd2_%0d", (a % 15) + 1), rdata2, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
